// File: rtl/gpu_cmd_processor.sv
// gpu_cmd_processor
//   Consumes a stream of 32-bit command words and turns them into GPU bus
//   register writes, shader uploads, kicks and idle waits.
//
//   Header word: opcode = [31:28], operand = [27:0]
//     0x0 NOP          completes on acceptance, no bus activity
//     0x1 WRITE_REG    addr = [15:0]; next word is the write data
//     0x2 WAIT_IDLE    polls status at address 0x4 until bit0 = 0
//     0x3 KICK         writes 0x1 to address 0x0
//     0x4 LOAD_SHADER  count N = [8:0]; next N words go to SHADER_BASE + 4*i
//     others           dropped, raise the sticky error flag
//
//   Ports
//     clk, rst          rising-edge clock, asynchronous active-high reset
//     i_cmd_valid/o_cmd_ready/i_cmd_data   command word handshake
//     o_bus_we/o_bus_addr/o_bus_wdata      registered GPU bus write port
//     i_bus_rdata       combinational read data for o_bus_addr
//     o_busy            high whenever not waiting for a new header
//     o_err             sticky error, cleared only by reset
//     o_cmd_count       completed-command counter, wraps at 16 bits
//
//   Build option
//     GPU_CMDP_TIMEOUT_EN  when defined, WAIT_IDLE gives up after
//                          TIMEOUT_CYCLES cycles, sets o_err and completes.
//                          When undefined no timeout counter exists.

module gpu_cmd_processor #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter logic [31:0] SHADER_BASE    = 32'h0000_1000,
   parameter int unsigned INSTR_DEPTH    = 256,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_cmd_valid,
   output logic                  o_cmd_ready,
   input  logic [DATA_WIDTH-1:0] i_cmd_data,
   output logic                  o_bus_we,
   output logic [ADDR_WIDTH-1:0] o_bus_addr,
   output logic [DATA_WIDTH-1:0] o_bus_wdata,
   input  logic [DATA_WIDTH-1:0] i_bus_rdata,
   output logic                  o_busy,
   output logic                  o_err,
   output logic [15:0]           o_cmd_count
);

   localparam logic [3:0] OP_NOP       = 4'h0;
   localparam logic [3:0] OP_WRITE_REG = 4'h1;
   localparam logic [3:0] OP_WAIT_IDLE = 4'h2;
   localparam logic [3:0] OP_KICK      = 4'h3;
   localparam logic [3:0] OP_LOAD_SH   = 4'h4;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_WR_DATA,
      ST_BUS_WR,
      ST_WAIT_IDLE,
      ST_SH_DATA
   } state_t;

   state_t                state_q, state_d;
   logic                  ready_q, ready_d;
   logic                  busy_q, busy_d;
   logic                  err_q, err_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [15:0]           count_q, count_d;
   logic [15:0]           wr_addr_q, wr_addr_d;
   logic [8:0]            sh_left_q, sh_left_d;
   logic [8:0]            sh_idx_q, sh_idx_d;
   logic [1:0]            settle_q, settle_d;
`ifdef GPU_CMDP_TIMEOUT_EN
   logic [31:0]           timer_q, timer_d;
`endif

   logic                  accept;
   logic                  cmd_done;
   logic [3:0]            hdr_op;
   logic [15:0]           hdr_addr;
   logic [8:0]            hdr_n;

   // Operand bits [27:16] and the upper status bits carry no meaning here.
   logic                  unused_bits;
   assign unused_bits = ^{i_cmd_data[27:16], i_bus_rdata[DATA_WIDTH-1:1],
                          TIMEOUT_CYCLES[0]};

   assign hdr_op   = i_cmd_data[31:28];
   assign hdr_addr = i_cmd_data[15:0];
   assign hdr_n    = i_cmd_data[8:0];
   assign accept   = i_cmd_valid & ready_q;

   always_comb begin
      state_d   = state_q;
      err_d     = err_q;
      we_d      = 1'b0;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wr_addr_d = wr_addr_q;
      sh_left_d = sh_left_q;
      sh_idx_d  = sh_idx_q;
      settle_d  = settle_q;
      cmd_done  = 1'b0;
`ifdef GPU_CMDP_TIMEOUT_EN
      timer_d   = timer_q;
`endif

      case (state_q)
         ST_FETCH: begin
            if (accept) begin
               case (hdr_op)
                  OP_NOP: cmd_done = 1'b1;
                  OP_WRITE_REG: begin
                     wr_addr_d = hdr_addr;
                     state_d   = ST_WR_DATA;
                  end
                  OP_WAIT_IDLE: begin
                     addr_d   = ADDR_WIDTH'(32'h4);
                     settle_d = 2'd0;
                     state_d  = ST_WAIT_IDLE;
`ifdef GPU_CMDP_TIMEOUT_EN
                     timer_d  = '0;
`endif
                  end
                  OP_KICK: begin
                     addr_d  = '0;
                     wdata_d = DATA_WIDTH'(32'h1);
                     we_d    = 1'b1;
                     state_d = ST_BUS_WR;
                  end
                  OP_LOAD_SH: begin
                     if (hdr_n == 9'd0) begin
                        cmd_done = 1'b1;
                     end else begin
                        sh_left_d = hdr_n;
                        sh_idx_d  = '0;
                        state_d   = ST_SH_DATA;
                        if (32'(hdr_n) > INSTR_DEPTH) err_d = 1'b1;
                     end
                  end
                  default: err_d = 1'b1;
               endcase
            end
         end

         ST_WR_DATA: begin
            if (accept) begin
               wdata_d = i_cmd_data;
               addr_d  = ADDR_WIDTH'(wr_addr_q);
               we_d    = 1'b1;
               state_d = ST_BUS_WR;
            end
         end

         // The write strobe was raised on entry; this cycle retires it.
         ST_BUS_WR: begin
            cmd_done = 1'b1;
            state_d  = ST_FETCH;
         end

         // The first two cycles ignore status while the GPU pipeline starts.
         ST_WAIT_IDLE: begin
            if (settle_q != 2'd2) begin
               settle_d = settle_q + 2'd1;
            end else if (!i_bus_rdata[0]) begin
               cmd_done = 1'b1;
               state_d  = ST_FETCH;
            end
`ifdef GPU_CMDP_TIMEOUT_EN
            timer_d = timer_q + 32'd1;
            if (state_d == ST_WAIT_IDLE && timer_q == TIMEOUT_CYCLES - 32'd1) begin
               err_d    = 1'b1;
               cmd_done = 1'b1;
               state_d  = ST_FETCH;
            end
`endif
         end

         // Words beyond INSTR_DEPTH are consumed but never written.
         ST_SH_DATA: begin
            if (accept) begin
               if (32'(sh_idx_q) < INSTR_DEPTH) begin
                  we_d    = 1'b1;
                  addr_d  = ADDR_WIDTH'(SHADER_BASE) + ADDR_WIDTH'({sh_idx_q, 2'b00});
                  wdata_d = i_cmd_data;
               end
               sh_idx_d  = sh_idx_q + 9'd1;
               sh_left_d = sh_left_q - 9'd1;
               if (sh_left_q == 9'd1) begin
                  cmd_done = 1'b1;
                  state_d  = ST_FETCH;
               end
            end
         end

         default: state_d = ST_FETCH;
      endcase

      count_d = cmd_done ? count_q + 16'd1 : count_q;
      ready_d = (state_d == ST_FETCH) || (state_d == ST_WR_DATA) ||
                (state_d == ST_SH_DATA);
      busy_d  = (state_d != ST_FETCH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_FETCH;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         count_q   <= '0;
         wr_addr_q <= '0;
         sh_left_q <= '0;
         sh_idx_q  <= '0;
         settle_q  <= '0;
`ifdef GPU_CMDP_TIMEOUT_EN
         timer_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         count_q   <= count_d;
         wr_addr_q <= wr_addr_d;
         sh_left_q <= sh_left_d;
         sh_idx_q  <= sh_idx_d;
         settle_q  <= settle_d;
`ifdef GPU_CMDP_TIMEOUT_EN
         timer_q   <= timer_d;
`endif
      end
   end

   assign o_cmd_ready = ready_q;
   assign o_busy      = busy_q;
   assign o_err       = err_q;
   assign o_bus_we    = we_q;
   assign o_bus_addr  = addr_q;
   assign o_bus_wdata = wdata_q;
   assign o_cmd_count = count_q;

endmodule

// File: tb/tb_gpu_cmd_processor.sv
// tb_gpu_cmd_processor
//   Self-checking bench for gpu_cmd_processor: a table of single commands,
//   hand-written multi-cycle sequences (shader upload, kick + idle wait,
//   status settle window, overflow, bad opcode, mid-command reset) and a
//   randomized command stream checked against a list-level reference model.

module tb_gpu_cmd_processor;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] BASE  = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_cmd_valid = 1'b0;
   logic        o_cmd_ready;
   logic [31:0] i_cmd_data = '0;
   logic        o_bus_we;
   logic [31:0] o_bus_addr;
   logic [31:0] o_bus_wdata;
   logic [31:0] i_bus_rdata = '0;
   logic        o_busy;
   logic        o_err;
   logic [15:0] o_cmd_count;

   gpu_cmd_processor #(
      .DATA_WIDTH    (32),
      .ADDR_WIDTH    (32),
      .SHADER_BASE   (BASE),
      .INSTR_DEPTH   (DEPTH),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_cmd_valid(i_cmd_valid),
      .o_cmd_ready(o_cmd_ready),
      .i_cmd_data (i_cmd_data),
      .o_bus_we   (o_bus_we),
      .o_bus_addr (o_bus_addr),
      .o_bus_wdata(o_bus_wdata),
      .i_bus_rdata(i_bus_rdata),
      .o_busy     (o_busy),
      .o_err      (o_err),
      .o_cmd_count(o_cmd_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      int          cyc;
   } wr_t;

   wr_t wq[$];

   // Every cycle with the write strobe high is one bus write.
   always @(negedge clk) begin
      if (!rst && o_bus_we) wq.push_back('{a: o_bus_addr, d: o_bus_wdata, cyc: cyc});
   end

   int n_checks = 0;
   int n_fail   = 0;
   int last_acc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one word and hold it until the DUT takes it (bounded).
   task automatic send(input logic [31:0] w);
      int guard = 0;
      i_cmd_valid = 1'b1;
      i_cmd_data  = w;
      while (!o_cmd_ready && guard < 200) begin
         tick(1);
         guard++;
      end
      if (!o_cmd_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: word 0x%0h not accepted, ready 0 expected 1", w);
         i_cmd_valid = 1'b0;
      end else begin
         tick(1);
         last_acc    = cyc;
         i_cmd_valid = 1'b0;
      end
   endtask

   task automatic settle();
      int guard = 0;
      while (o_busy && guard < 500) begin
         tick(1);
         guard++;
      end
      if (o_busy) begin
         n_checks++;
         n_fail++;
         $display("FAIL settle_timeout: busy 1, expected 0");
      end
      tick(2);
   endtask

   task automatic do_reset();
      i_cmd_valid = 1'b0;
      i_bus_rdata = '0;
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
      wq.delete();
   endtask

   typedef struct {
      logic [31:0] hdr;
      logic [31:0] dat;
      bit          has_dat;
      int          nwr;
      logic [31:0] ea;
      logic [31:0] ed;
   } vec_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } pair_t;

   vec_t        vt[6];
   pair_t       ew[$];
   logic [15:0] cnt0;
   int          acc;
   int          ecount;
   bit          eerr;
   logic [31:0] r;

   initial begin
      vt[0] = '{hdr: 32'h1000_0008, dat: 32'h0000_4000, has_dat: 1'b1, nwr: 1, ea: 32'h8,    ed: 32'h4000};
      vt[1] = '{hdr: 32'h0000_0000, dat: 32'h0,         has_dat: 1'b0, nwr: 0, ea: 32'h0,    ed: 32'h0};
      vt[2] = '{hdr: 32'h1ABC_FFFF, dat: 32'hDEAD_BEEF, has_dat: 1'b1, nwr: 1, ea: 32'hFFFF, ed: 32'hDEAD_BEEF};
      vt[3] = '{hdr: 32'h3123_4567, dat: 32'h0,         has_dat: 1'b0, nwr: 1, ea: 32'h0,    ed: 32'h1};
      vt[4] = '{hdr: 32'h4FFF_FE00, dat: 32'h0,         has_dat: 1'b0, nwr: 0, ea: 32'h0,    ed: 32'h0};
      vt[5] = '{hdr: 32'h0FFF_FFFF, dat: 32'h0,         has_dat: 1'b0, nwr: 0, ea: 32'h0,    ed: 32'h0};

      // Asynchronous reset takes effect before any clock edge.
      #1 rst = 1'b1;
      #2;
      check("rst_we",    32'(o_bus_we),    32'h0);
      check("rst_addr",  o_bus_addr,       32'h0);
      check("rst_wdata", o_bus_wdata,      32'h0);
      check("rst_busy",  32'(o_busy),      32'h0);
      check("rst_err",   32'(o_err),       32'h0);
      check("rst_count", 32'(o_cmd_count), 32'h0);
      check("rst_ready", 32'(o_cmd_ready), 32'h0);
      tick(2);
      rst = 1'b0;
      tick(1);
      check("post_rst_ready", 32'(o_cmd_ready), 32'h1);

      // Single-command table; first entry leaves the counter at exactly 1.
      for (int i = 0; i < 6; i++) begin
         cnt0 = o_cmd_count;
         wq.delete();
         send(vt[i].hdr);
         if (vt[i].has_dat) send(vt[i].dat);
         acc = last_acc;
         settle();
         check($sformatf("vec%0d_nwr", i), 32'(wq.size()), 32'(vt[i].nwr));
         if (vt[i].nwr == 1 && wq.size() == 1) begin
            check($sformatf("vec%0d_addr", i),  wq[0].a,          vt[i].ea);
            check($sformatf("vec%0d_wdata", i), wq[0].d,          vt[i].ed);
            check($sformatf("vec%0d_wrcyc", i), 32'(wq[0].cyc),   32'(acc));
         end
         check($sformatf("vec%0d_count", i), 32'(o_cmd_count), 32'(cnt0 + 16'd1));
         check($sformatf("vec%0d_err", i),   32'(o_err),       32'h0);
      end

      // Shader upload of three words.
      cnt0 = o_cmd_count;
      wq.delete();
      send(32'h4000_0003);
      send(32'hA0A0_0001);
      send(32'hB0B0_0002);
      send(32'hC0C0_0003);
      settle();
      check("sh3_nwr", 32'(wq.size()), 32'd3);
      if (wq.size() == 3) begin
         check("sh3_a0", wq[0].a, 32'h1000);
         check("sh3_d0", wq[0].d, 32'hA0A0_0001);
         check("sh3_a1", wq[1].a, 32'h1004);
         check("sh3_d1", wq[1].d, 32'hB0B0_0002);
         check("sh3_a2", wq[2].a, 32'h1008);
         check("sh3_d2", wq[2].d, 32'hC0C0_0003);
      end
      check("sh3_err",   32'(o_err),       32'h0);
      check("sh3_count", 32'(o_cmd_count), 32'(cnt0 + 16'd1));

      // KICK followed by WAIT_IDLE: status busy for 10 cycles, then idle.
      cnt0 = o_cmd_count;
      wq.delete();
      i_bus_rdata = 32'h1;
      send(32'h3000_0000);
      acc = last_acc;
      send(32'h2000_0000);
      for (int k = 0; k < 10; k++) begin
         check($sformatf("kw_busy%0d", k), 32'(o_busy),   32'h1);
         check($sformatf("kw_addr%0d", k), o_bus_addr,    32'h4);
         check($sformatf("kw_we%0d", k),   32'(o_bus_we), 32'h0);
         tick(1);
      end
      i_bus_rdata = 32'hFFFF_FFFE;
      check("kw_busy_last", 32'(o_busy), 32'h1);
      tick(1);
      check("kw_done_busy",  32'(o_busy),      32'h0);
      check("kw_done_count", 32'(o_cmd_count), 32'(cnt0 + 16'd2));
      check("kw_nwr",        32'(wq.size()),   32'd1);
      if (wq.size() == 1) begin
         check("kw_addr",  wq[0].a,        32'h0);
         check("kw_wdata", wq[0].d,        32'h1);
         check("kw_wrcyc", 32'(wq[0].cyc), 32'(acc));
      end

      // Status reads idle from the start: still exactly three cycles busy.
      i_bus_rdata = 32'h0;
      send(32'h2000_0000);
      check("wi_c1", 32'(o_busy), 32'h1);
      tick(1);
      check("wi_c2", 32'(o_busy), 32'h1);
      tick(1);
      check("wi_c3", 32'(o_busy), 32'h1);
      tick(1);
      check("wi_done", 32'(o_busy), 32'h0);
      tick(1);

      // Shader count beyond INSTR_DEPTH: all words consumed, only DEPTH written.
      cnt0 = o_cmd_count;
      wq.delete();
      send(32'h4000_0006);
      for (int k = 0; k < 6; k++) send(32'h5500_0000 + 32'(k));
      settle();
      check("ov_nwr", 32'(wq.size()), 32'(DEPTH));
      for (int k = 0; k < wq.size(); k++) begin
         check($sformatf("ov_a%0d", k), wq[k].a, BASE + 32'(4 * k));
         check($sformatf("ov_d%0d", k), wq[k].d, 32'h5500_0000 + 32'(k));
      end
      check("ov_err",   32'(o_err),       32'h1);
      check("ov_count", 32'(o_cmd_count), 32'(cnt0 + 16'd1));

      // Undefined opcode then NOP.
      do_reset();
      send(32'hF000_0000);
      tick(1);
      check("bad_err",   32'(o_err),       32'h1);
      check("bad_count", 32'(o_cmd_count), 32'h0);
      send(32'h0000_0000);
      settle();
      check("bad_nop_count", 32'(o_cmd_count), 32'h1);
      check("bad_nwr",       32'(wq.size()),   32'h0);
      check("bad_err_hold",  32'(o_err),       32'h1);

      // Reset in the middle of a three-word shader upload.
      do_reset();
      send(32'h4000_0003);
      send(32'hAAAA_0001);
      tick(1);
      #2 rst = 1'b1;
      #1;
      check("mr_we",    32'(o_bus_we),    32'h0);
      check("mr_addr",  o_bus_addr,       32'h0);
      check("mr_wdata", o_bus_wdata,      32'h0);
      check("mr_busy",  32'(o_busy),      32'h0);
      check("mr_err",   32'(o_err),       32'h0);
      check("mr_count", 32'(o_cmd_count), 32'h0);
      check("mr_ready", 32'(o_cmd_ready), 32'h0);
      tick(1);
      rst = 1'b0;
      tick(1);
      check("mr_fetch_ready", 32'(o_cmd_ready), 32'h1);
      check("mr_fetch_busy",  32'(o_busy),      32'h0);
      check("mr_nwr",         32'(wq.size()),   32'h1);
      wq.delete();
      send(32'h1000_0010);
      send(32'h0000_0055);
      settle();
      check("mr_wr_nwr", 32'(wq.size()), 32'h1);
      if (wq.size() == 1) begin
         check("mr_wr_addr",  wq[0].a, 32'h10);
         check("mr_wr_wdata", wq[0].d, 32'h55);
      end
      check("mr_wr_count", 32'(o_cmd_count), 32'h1);
      check("mr_wr_err",   32'(o_err),       32'h0);

      // Randomized stream against a list-level model of the command rules.
      do_reset();
      ew.delete();
      ecount = 0;
      eerr   = 1'b0;
      for (int k = 0; k < 40; k++) begin
         int          op;
         int          n;
         logic [15:0] a16;
         logic [31:0] d;
         op = $urandom_range(0, 5);
         case (op)
            0: begin
               send({4'h0, 28'($urandom)});
               ecount++;
            end
            1: begin
               a16 = 16'($urandom);
               d   = $urandom;
               send({4'h1, 12'($urandom), a16});
               tick($urandom_range(0, 2));
               send(d);
               ew.push_back('{a: 32'(a16), d: d});
               ecount++;
            end
            2: begin
               send({4'h3, 28'($urandom)});
               ew.push_back('{a: 32'h0, d: 32'h1});
               ecount++;
            end
            3: begin
               n = $urandom_range(0, 6);
               send({4'h4, 19'($urandom), 9'(n)});
               for (int i = 0; i < n; i++) begin
                  d = $urandom;
                  send(d);
                  if (i < DEPTH) ew.push_back('{a: BASE + 32'(4 * i), d: d});
               end
               if (n > DEPTH) eerr = 1'b1;
               ecount++;
            end
            4: begin
               n = $urandom_range(0, 12);
               r = $urandom;
               send({4'h2, 28'($urandom)});
               i_bus_rdata = r | 32'h1;
               tick(n);
               i_bus_rdata = r & 32'hFFFF_FFFE;
               ecount++;
            end
            default: begin
               send({4'($urandom_range(5, 15)), 28'($urandom)});
               eerr = 1'b1;
            end
         endcase
         tick($urandom_range(0, 1));
      end
      settle();
      check("rnd_nwr", 32'(wq.size()), 32'(ew.size()));
      for (int i = 0; i < wq.size() && i < ew.size(); i++) begin
         check($sformatf("rnd_a%0d", i), wq[i].a, ew[i].a);
         check($sformatf("rnd_d%0d", i), wq[i].d, ew[i].d);
      end
      check("rnd_count", 32'(o_cmd_count), 32'(16'(ecount)));
      check("rnd_err",   32'(o_err),       32'(eerr));

`ifdef GPU_CMDP_TIMEOUT_EN
      // Status never goes idle: timeout after 16 cycles.
      do_reset();
      i_bus_rdata = 32'h1;
      send(32'h2000_0000);
      tick(15);
      check("to_busy15", 32'(o_busy), 32'h1);
      check("to_err15",  32'(o_err),  32'h0);
      tick(1);
      check("to_busy16", 32'(o_busy),      32'h0);
      check("to_err",    32'(o_err),       32'h1);
      check("to_count",  32'(o_cmd_count), 32'h1);
      check("to_ready",  32'(o_cmd_ready), 32'h1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1);
   end

endmodule
